control: RTL and testbench



---
 rtl/control.sv | 146 ++++++++++++++
 tb/tb_control.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control.sv
`default_nettype none
// ============================================================================
//  Module   : control
//  Purpose  : Main control decoder for a single-cycle MIPS datapath. Decodes
//             the 6-bit opcode into datapath steering signals and registers
//             them on the rising clock edge.
//  Ports    :
//    clk       in   1  system clock
//    rst_n     in   1  synchronous active-low reset (clears all outputs)
//    op        in   6  instruction opcode, instr[31:26]
//    RegDst    out  1  write address select: 1 = rd, 0 = rt
//    Jump      out  1  PC source is the jump target
//    ALUsrc    out  1  ALU operand B: 1 = sign-extended immediate, 0 = rt
//    ALUop     out  2  ALU class: 00 add, 01 subtract, 10 funct field
//    MemToReg  out  1  write-back select: 1 = memory data, 0 = ALU result
//    MemRead   out  1  data-memory read enable
//    MemWrite  out  1  data-memory write enable
//    Branch    out  1  conditional branch (qualified by ALU zero elsewhere)
//    RegWrite  out  1  register-file write enable
//  Revision : 1.0  initial release
// ============================================================================
module control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  output logic       RegDst,
  output logic       Jump,
  output logic       ALUsrc,
  output logic [1:0] ALUop,
  output logic       MemToReg,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       Branch,
  output logic       RegWrite
);

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;

  localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
  localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
  localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

  logic       w_reg_dst;
  logic       w_jump;
  logic       w_alu_src;
  logic [1:0] w_alu_op;
  logic       w_mem_to_reg;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_branch;
  logic       w_reg_write;

  logic       r_reg_dst;
  logic       r_jump;
  logic       r_alu_src;
  logic [1:0] r_alu_op;
  logic       r_mem_to_reg;
  logic       r_mem_read;
  logic       r_mem_write;
  logic       r_branch;
  logic       r_reg_write;

  // Everything defaults to zero, so don't-care fields of sw/beq/j and all
  // unrecognised opcodes (NOP) come out as deterministic zeros.
  always_comb begin
    w_reg_dst    = 1'b0;
    w_jump       = 1'b0;
    w_alu_src    = 1'b0;
    w_alu_op     = c_ALUOP_ADD;
    w_mem_to_reg = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_branch     = 1'b0;
    w_reg_write  = 1'b0;
    case (op)
      c_OP_RTYPE: begin
        w_reg_dst   = 1'b1;
        w_alu_op    = c_ALUOP_FUNCT;
        w_reg_write = 1'b1;
      end
      c_OP_LW: begin
        w_alu_src    = 1'b1;
        w_mem_to_reg = 1'b1;
        w_mem_read   = 1'b1;
        w_reg_write  = 1'b1;
      end
      c_OP_SW: begin
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      c_OP_BEQ: begin
        w_alu_op = c_ALUOP_SUB;
        w_branch = 1'b1;
      end
      c_OP_J: begin
        w_jump = 1'b1;
      end
      c_OP_ADDI: begin
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_reg_dst    <= 1'b0;
      r_jump       <= 1'b0;
      r_alu_src    <= 1'b0;
      r_alu_op     <= c_ALUOP_ADD;
      r_mem_to_reg <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_branch     <= 1'b0;
      r_reg_write  <= 1'b0;
    end else begin
      r_reg_dst    <= w_reg_dst;
      r_jump       <= w_jump;
      r_alu_src    <= w_alu_src;
      r_alu_op     <= w_alu_op;
      r_mem_to_reg <= w_mem_to_reg;
      r_mem_read   <= w_mem_read;
      r_mem_write  <= w_mem_write;
      r_branch     <= w_branch;
      r_reg_write  <= w_reg_write;
    end
  end

  assign RegDst   = r_reg_dst;
  assign Jump     = r_jump;
  assign ALUsrc   = r_alu_src;
  assign ALUop    = r_alu_op;
  assign MemToReg = r_mem_to_reg;
  assign MemRead  = r_mem_read;
  assign MemWrite = r_mem_write;
  assign Branch   = r_branch;
  assign RegWrite = r_reg_write;

endmodule
`default_nettype wire

// File: tb/tb_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_control
//  Purpose  : Self-checking bench for the control decoder. Directed scenarios
//             plus a randomized run compared against a table-driven model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       RegDst, Jump, ALUsrc, MemToReg, MemRead, MemWrite, Branch, RegWrite;
  logic [1:0] ALUop;

  int checks = 0;
  int errors = 0;

  control dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op       (op),
    .RegDst   (RegDst),
    .Jump     (Jump),
    .ALUsrc   (ALUsrc),
    .ALUop    (ALUop),
    .MemToReg (MemToReg),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Branch   (Branch),
    .RegWrite (RegWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed order: RegDst, Jump, ALUsrc, ALUop[1:0], MemToReg, MemRead,
  // MemWrite, Branch, RegWrite.
  localparam logic [9:0] c_V_R    = 10'b1_0_0_10_0_0_0_0_1;
  localparam logic [9:0] c_V_LW   = 10'b0_0_1_00_1_1_0_0_1;
  localparam logic [9:0] c_V_SW   = 10'b0_0_1_00_0_0_1_0_0;
  localparam logic [9:0] c_V_BEQ  = 10'b0_0_0_01_0_0_0_1_0;
  localparam logic [9:0] c_V_J    = 10'b0_1_0_00_0_0_0_0_0;
  localparam logic [9:0] c_V_ADDI = 10'b0_0_1_00_0_0_0_0_1;

  logic [5:0] tbl_op  [6];
  logic [9:0] tbl_val [6];

  initial begin
    tbl_op[0] = 6'b000000; tbl_val[0] = c_V_R;
    tbl_op[1] = 6'b100011; tbl_val[1] = c_V_LW;
    tbl_op[2] = 6'b101011; tbl_val[2] = c_V_SW;
    tbl_op[3] = 6'b000100; tbl_val[3] = c_V_BEQ;
    tbl_op[4] = 6'b000010; tbl_val[4] = c_V_J;
    tbl_op[5] = 6'b001000; tbl_val[5] = c_V_ADDI;
  end

  // Reference: table lookup; anything not listed is a NOP.
  function automatic logic [9:0] model(input logic [5:0] o);
    logic [9:0] v;
    v = 10'b0;
    for (int k = 0; k < 6; k++)
      if (tbl_op[k] == o) v = tbl_val[k];
    return v;
  endfunction

  function automatic logic [9:0] outs();
    return {RegDst, Jump, ALUsrc, ALUop, MemToReg, MemRead, MemWrite, Branch, RegWrite};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    op    = 6'b100011;
    tick();
    checks++;
    if (outs() !== 10'b0) begin
      errors++;
      $display("FAIL reset_zero: got %b expected %b", outs(), 10'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    op    = 6'b000000;
    tick();
    checks++;
    if (outs() !== c_V_R) begin
      errors++;
      $display("FAIL reset_release_rtype: got %b expected %b", outs(), c_V_R);
    end
  endtask

  task automatic test_pair(input string name, input logic [5:0] op_a, input logic [9:0] exp_a,
                           input logic [5:0] op_b, input logic [9:0] exp_b);
    @(negedge clk);
    op = op_a;
    tick();
    checks++;
    if (outs() !== exp_a) begin
      errors++;
      $display("FAIL %s_first: op=%b got %b expected %b", name, op_a, outs(), exp_a);
    end
    @(negedge clk);
    op = op_b;
    tick();
    checks++;
    if (outs() !== exp_b) begin
      errors++;
      $display("FAIL %s_second: op=%b got %b expected %b", name, op_b, outs(), exp_b);
    end
  endtask

  task automatic test_lw_sw();
    test_pair("lw_sw", 6'b100011, c_V_LW, 6'b101011, c_V_SW);
  endtask

  task automatic test_beq_j();
    test_pair("beq_j", 6'b000100, c_V_BEQ, 6'b000010, c_V_J);
  endtask

  task automatic test_addi_illegal();
    test_pair("addi_illegal", 6'b001000, c_V_ADDI, 6'b111111, 10'b0);
  endtask

  task automatic test_latency_midreset();
    @(negedge clk);
    op = 6'b100011;
    tick();
    checks++;
    if (outs() !== c_V_LW) begin
      errors++;
      $display("FAIL latency_lw: got %b expected %b", outs(), c_V_LW);
    end
    // Change op between edges: outputs must hold until the next edge.
    @(negedge clk);
    op = 6'b101011;
    #2;
    checks++;
    if (outs() !== c_V_LW) begin
      errors++;
      $display("FAIL latency_hold: got %b expected %b", outs(), c_V_LW);
    end
    tick();
    checks++;
    if (outs() !== c_V_SW) begin
      errors++;
      $display("FAIL latency_update: got %b expected %b", outs(), c_V_SW);
    end
    @(negedge clk);
    op = 6'b000000;
    tick();
    checks++;
    if (outs() !== c_V_R) begin
      errors++;
      $display("FAIL midreset_pre: got %b expected %b", outs(), c_V_R);
    end
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    checks++;
    if (outs() !== 10'b0) begin
      errors++;
      $display("FAIL midreset_zero: got %b expected %b", outs(), 10'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    op    = 6'b000100;
    tick();
    checks++;
    if (outs() !== c_V_BEQ) begin
      errors++;
      $display("FAIL midreset_release: got %b expected %b", outs(), c_V_BEQ);
    end
  endtask

  task automatic test_sweep();
    logic [9:0] exp;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      op = 6'(i);
      tick();
      exp = model(6'(i));
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL sweep_decode: op=%b got %b expected %b", 6'(i), outs(), exp);
      end
      checks++;
      if ((MemRead & MemWrite) !== 1'b0 || (Jump & Branch) !== 1'b0) begin
        errors++;
        $display("FAIL sweep_invariant: op=%b MemRead=%b MemWrite=%b Jump=%b Branch=%b expected no overlap",
                 6'(i), MemRead, MemWrite, Jump, Branch);
      end
    end
  endtask

  task automatic test_random();
    logic [9:0] exp;
    logic [5:0] o;
    logic       r;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 1) == 0) o = tbl_op[$urandom_range(0, 5)];
      else                           o = 6'($urandom_range(0, 63));
      r     = ($urandom_range(0, 9) != 0);
      op    = o;
      rst_n = r;
      tick();
      exp = r ? model(o) : 10'b0;
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL random_decode: op=%b rst_n=%b got %b expected %b", o, r, outs(), exp);
      end
      checks++;
      if ((MemRead & MemWrite) !== 1'b0 || (Jump & Branch) !== 1'b0 ||
          (MemWrite & RegWrite) !== 1'b0) begin
        errors++;
        $display("FAIL random_invariant: op=%b got %b expected exclusive fields", o, outs());
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    op    = 6'b0;
    test_reset();
    test_lw_sw();
    test_beq_j();
    test_addi_illegal();
    test_latency_midreset();
    test_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
